// File: rtl/data_mem_pkg.sv
// Shared constants, FSM state type and lane helpers for the byte-addressed data memory.
package data_mem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic {
        StInit,
        StRun
    } mem_state_e;

    // Byte-lane write mask for a store of the given size at the given byte offset.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SIZE_B:  be = 4'b0001 << addr_lo;
            SIZE_H:  be = addr_lo[1] ? 4'b1100 : 4'b0011;
            SIZE_W:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate store data across lanes so the byte-enable mask picks the right copy.
    function automatic logic [31:0] store_replicate(input logic [1:0] size,
                                                    input logic [31:0] wdata);
        logic [31:0] rep;
        case (size)
            SIZE_B:  rep = {4{wdata[7:0]}};
            SIZE_H:  rep = {2{wdata[15:0]}};
            default: rep = wdata;
        endcase
        return rep;
    endfunction

    // Select the addressed lane of a word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  addr_lo,
                                                 input logic        is_unsigned);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {addr_lo, 3'b000};
        case (size)
            SIZE_B:  res = is_unsigned ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            SIZE_H:  res = is_unsigned ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            SIZE_W:  res = sh;
            default: res = 32'h0;
        endcase
        return res;
    endfunction

    // Natural-alignment violation; illegal sizes are flagged separately.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_H:  bad = addr_lo[0];
            SIZE_W:  bad = (addr_lo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Fixed-latency response shift register: valid, read data and error travel together.
module mem_resp_pipe #(
    parameter int unsigned READ_LAT = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    input  logic [31:0] in_rdata_i,
    input  logic        in_err_i,
    output logic        out_valid_o,
    output logic [31:0] out_rdata_o,
    output logic        out_err_o
);

    logic [READ_LAT-1:0] valid_q, valid_d;
    logic [READ_LAT-1:0] err_q, err_d;
    logic [31:0]         rdata_q [READ_LAT];
    logic [31:0]         rdata_d [READ_LAT];

    // Shift every stage one step towards the output each cycle.
    always_comb begin
        valid_d    = '0;
        err_d      = '0;
        for (int i = 0; i < READ_LAT; i++) begin
            rdata_d[i] = '0;
        end
        valid_d[0] = in_valid_i;
        err_d[0]   = in_err_i;
        rdata_d[0] = in_rdata_i;
        for (int i = 1; i < READ_LAT; i++) begin
            valid_d[i] = valid_q[i-1];
            err_d[i]   = err_q[i-1];
            rdata_d[i] = rdata_q[i-1];
        end
    end

    // Stage registers; reset drops everything in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            for (int i = 0; i < READ_LAT; i++) begin
                rdata_q[i] <= rdata_d[i];
            end
        end
    end

    assign out_valid_o = valid_q[READ_LAT-1];
    assign out_err_o   = err_q[READ_LAT-1];
    assign out_rdata_o = rdata_q[READ_LAT-1];

endmodule

// File: rtl/data_memory_ls.sv
// Byte-addressed data memory with sized loads/stores, error reporting and fixed read latency.
module data_memory_ls
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH          = 256,
    parameter int unsigned READ_LAT       = 1,
    parameter int unsigned CLEAR_ON_RESET = 1,
    parameter int unsigned ADDR_W         = $clog2(DEPTH * 4)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    mem_state_e       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [31:0]      mem_q [DEPTH];

    logic             init_we;
    logic             accept;
    logic [IDX_W-1:0] idx;
    logic [1:0]       lo;
    logic             range_bad;
    logic             req_err;
    logic             st_we;
    logic [3:0]       st_be;
    logic [31:0]      st_data;
    logic [31:0]      rd_word;
    logic [31:0]      resp_rdata_d;

    // State register: reset picks the clearing sweep or goes straight to service.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= (CLEAR_ON_RESET != 0) ? StInit : StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: sweep one word per cycle, leave after clearing the last word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StInit: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun:   state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    // FSM outputs: accept only in service, clear only while sweeping.
    always_comb begin
        req_ready = 1'b0;
        init_we   = 1'b0;
        if (!rst) begin
            req_ready = (state_q == StRun);
            init_we   = (state_q == StInit);
        end
    end

    assign accept = req_valid && req_ready;
    assign idx    = req_addr[ADDR_W-1:2];
    assign lo     = req_addr[1:0];

    // Request decode: error classification, store lanes and load lane selection.
    always_comb begin
        range_bad    = (32'(idx) >= DEPTH);
        req_err      = (req_size == 2'b11) || misaligned(req_size, lo) || range_bad;
        st_we        = accept && req_we && !req_err;
        st_be        = byte_en(req_size, lo);
        st_data      = store_replicate(req_size, req_wdata);
        rd_word      = range_bad ? 32'h0 : mem_q[idx];
        resp_rdata_d = 32'h0;
        if (!req_we && !req_err) begin
            resp_rdata_d = load_extract(rd_word, req_size, lo, req_unsigned);
        end
    end

    // Storage: contents are never reset, only swept to zero by the clearing pass.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem_q[cnt_q] <= '0;
        end else if (st_we) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) begin
                    mem_q[idx][8*b +: 8] <= st_data[8*b +: 8];
                end
            end
        end
    end

    mem_resp_pipe #(
        .READ_LAT(READ_LAT)
    ) u_resp_pipe (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (accept),
        .in_rdata_i (resp_rdata_d),
        .in_err_i   (req_err),
        .out_valid_o(resp_valid),
        .out_rdata_o(resp_rdata),
        .out_err_o  (resp_err)
    );

endmodule

// File: tb/tb_data_memory_ls.sv
// Randomised bench for data_memory_ls against a byte-array reference model.
module tb_data_memory_ls;

    localparam int unsigned DEPTH_A = 16;
    localparam int unsigned LAT_A   = 3;
    localparam int unsigned DEPTH_B = 12;
    localparam int unsigned LAT_B   = 4;
    localparam int unsigned AW      = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_a = 1'b1, rst_b = 1'b1;
    logic          valid_a = 1'b0, valid_b = 1'b0;
    logic          we = 1'b0;
    logic [1:0]    size = 2'b00;
    logic          uns = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [31:0]   wdata = '0;

    logic          ready_a, resp_valid_a, err_a;
    logic [31:0]   rdata_a;
    logic          ready_b, resp_valid_b, err_b;
    logic [31:0]   rdata_b;

    data_memory_ls #(
        .DEPTH(DEPTH_A), .READ_LAT(LAT_A), .CLEAR_ON_RESET(1)
    ) u_dut_a (
        .clk(clk), .rst(rst_a), .req_valid(valid_a), .req_ready(ready_a), .req_we(we),
        .req_size(size), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
        .resp_valid(resp_valid_a), .resp_rdata(rdata_a), .resp_err(err_a)
    );

    data_memory_ls #(
        .DEPTH(DEPTH_B), .READ_LAT(LAT_B), .CLEAR_ON_RESET(0)
    ) u_dut_b (
        .clk(clk), .rst(rst_b), .req_valid(valid_b), .req_ready(ready_b), .req_we(we),
        .req_size(size), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
        .resp_valid(resp_valid_b), .resp_rdata(rdata_b), .resp_err(err_b)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [7:0]  mb [2][64];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Response monitors: a pulse must appear exactly on the due cycle of the oldest entry.
    always @(negedge clk) begin : mon_a
        exp_t e;
        logic ev;
        ev = (q_a.size() > 0) && (q_a[0].due == cyc);
        if (resp_valid_a || ev) begin
            check("a_resp_valid", resp_valid_a, ev);
            if (ev) begin
                e = q_a.pop_front();
                check("a_rdata", rdata_a, e.rdata);
                check("a_err", err_a, e.err);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        logic ev;
        ev = (q_b.size() > 0) && (q_b[0].due == cyc);
        if (resp_valid_b || ev) begin
            check("b_resp_valid", resp_valid_b, ev);
            if (ev) begin
                e = q_b.pop_front();
                check("b_rdata", rdata_b, e.rdata);
                check("b_err", err_b, e.err);
            end
        end
    end

    function automatic logic rdy(input int id);
        return (id == 0) ? ready_a : ready_b;
    endfunction

    // One request, one cycle; the model decides the outcome from byte-level rules.
    task automatic issue(input int id, input logic w, input logic [1:0] sz, input logic u,
                         input logic [AW-1:0] a, input logic [31:0] d);
        int          t;
        int          nb;
        int          dep;
        int          ai;
        exp_t        e;
        logic [63:0] val;
        logic [63:0] mask;
        t = 0;
        @(negedge clk); #1;
        while (!rdy(id) && t < 200) begin
            t++;
            @(negedge clk); #1;
        end
        if (!rdy(id)) begin
            check("ready_timeout", 32'd0, 32'd1);
            return;
        end
        we = w; size = sz; uns = u; addr = a; wdata = d;
        if (id == 0) valid_a = 1'b1; else valid_b = 1'b1;
        dep     = (id == 0) ? DEPTH_A : DEPTH_B;
        ai      = int'(a);
        nb      = 1 << sz;
        e.err   = (sz == 2'b11) || ((ai % nb) != 0) || ((ai / 4) >= dep);
        e.rdata = 32'h0;
        e.due   = cyc + ((id == 0) ? LAT_A : LAT_B);
        if (!e.err) begin
            if (w) begin
                for (int i = 0; i < nb; i++) mb[id][ai+i] = d[8*i +: 8];
            end else begin
                val = 64'h0;
                for (int i = 0; i < nb; i++) val = val | (64'(mb[id][ai+i]) << (8 * i));
                mask = (64'd1 << (8 * nb)) - 64'd1;
                if (!u && val[8*nb-1]) val = val | ~mask;
                e.rdata = val[31:0];
            end
        end
        if (id == 0) q_a.push_back(e); else q_b.push_back(e);
        @(posedge clk); #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    // Reset for one cycle; anything still in flight is forgotten.
    task automatic do_reset(input int id);
        @(negedge clk); #1;
        if (id == 0) rst_a = 1'b1; else rst_b = 1'b1;
        @(posedge clk); #1;
        if (id == 0) q_a.delete(); else q_b.delete();
        @(negedge clk); #1;
        if (id == 0) begin
            rst_a = 1'b0;
            for (int i = 0; i < 64; i++) mb[0][i] = 8'h0;
        end else begin
            rst_b = 1'b0;
        end
        #1;
    endtask

    task automatic sweep_len(output int n);
        n = 0;
        while (!ready_a && n < 100) begin
            n++;
            @(negedge clk); #1;
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int            n;
        int            id;
        int            r;
        logic [1:0]    sz;
        logic [AW-1:0] a;

        // Clearing sweep after reset.
        do_reset(0);
        check("rst_ready_a", ready_a, 1'b0);
        check("rst_resp_valid_a", resp_valid_a, 1'b0);
        check("rst_rdata_a", rdata_a, 32'h0);
        check("rst_err_a", err_a, 1'b0);
        sweep_len(n);
        check("sweep_len", n, 16);
        check("ready_after_sweep", ready_a, 1'b1);

        do_reset(1);
        check("rst_ready_b", ready_b, 1'b1);
        check("rst_resp_valid_b", resp_valid_b, 1'b0);

        // Reset in the middle of the sweep restarts it.
        do_reset(0);
        repeat (5) @(negedge clk);
        do_reset(0);
        sweep_len(n);
        check("sweep_restart_len", n, 16);

        // Directed functional cases on the cleared instance.
        issue(0, 1'b0, 2'b10, 1'b0, 6'h3C, 32'h0);
        issue(0, 1'b1, 2'b10, 1'b0, 6'h10, 32'h8081_82F3);
        issue(0, 1'b1, 2'b00, 1'b0, 6'h11, 32'h0000_007F);
        issue(0, 1'b0, 2'b10, 1'b0, 6'h10, 32'h0);
        issue(0, 1'b0, 2'b00, 1'b0, 6'h13, 32'h0);
        issue(0, 1'b0, 2'b01, 1'b1, 6'h12, 32'h0);
        issue(0, 1'b0, 2'b01, 1'b0, 6'h03, 32'h0);
        issue(0, 1'b1, 2'b10, 1'b0, 6'h06, 32'h1234_5678);
        issue(0, 1'b0, 2'b10, 1'b0, 6'h04, 32'h0);
        issue(0, 1'b0, 2'b11, 1'b0, 6'h08, 32'h0);
        issue(0, 1'b1, 2'b11, 1'b0, 6'h08, 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) issue(0, 1'b0, 2'b10, 1'b0, 6'(4 * i + 16), 32'h0);
        issue(0, 1'b1, 2'b10, 1'b0, 6'h20, 32'hDEAD_BEEF);
        issue(0, 1'b0, 2'b10, 1'b0, 6'h20, 32'h0);

        // Fill the retained-contents instance so every word is known, then probe range.
        for (int i = 0; i < 12; i++) issue(1, 1'b1, 2'b10, 1'b0, 6'(4 * i), $urandom);
        issue(1, 1'b0, 2'b10, 1'b0, 6'h30, 32'h0);
        issue(1, 1'b1, 2'b00, 1'b0, 6'h3F, 32'hAB);

        // Random mix on both instances.
        for (int k = 0; k < 400; k++) begin
            id = $urandom_range(0, 1);
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            a  = AW'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            issue(id, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end

        // Reset with two loads in flight: both responses vanish, stored data survives.
        issue(1, 1'b1, 2'b10, 1'b0, 6'h08, 32'hCAFE_F00D);
        issue(1, 1'b0, 2'b10, 1'b0, 6'h00, 32'h0);
        issue(1, 1'b0, 2'b10, 1'b0, 6'h04, 32'h0);
        do_reset(1);
        for (int i = 0; i < 8; i++) begin
            check("b_no_resp_after_rst", resp_valid_b, 1'b0);
            @(negedge clk); #1;
        end
        issue(1, 1'b0, 2'b10, 1'b0, 6'h08, 32'h0);

        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("drain_outstanding", q_a.size() + q_b.size(), 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
